mem_aw_burst_issuer: RTL and testbench



---
 rtl/mem_aw_burst_issuer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mem_aw_burst_issuer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_aw_burst_issuer.sv
// mem_aw_burst_issuer
//
// Sits downstream of the 4KB request splitter. Requests (address, byte size)
// are queued in a small FIFO. Each request is then broken into AXI
// write-address bursts. A burst is limited by MAX_BURST_BEATS and never
// crosses a 4KB boundary. pop_request pulses for one cycle once the last
// burst of the head request has been accepted.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   req_addr        request start address (low beat-offset bits ignored)
//   req_size_bytes  request size in bytes (0 = no burst, only a pop)
//   req_valid       single-cycle request strobe
//   req_ready       FIFO has at least one free entry
//   pop_request     one-cycle pulse: head request fully issued
//   m_awaddr/m_awlen/m_awvalid/m_awready   AXI write-address channel
//   busy            FIFO non-empty or FSM not IDLE
//   overflow_err    sticky: req_valid seen while FIFO full
//
// Optional feature macro: MEM_AW_BURST_ISSUER_STATS_EN
//   Adds stat_bursts (AW handshakes) and stat_requests (pop_request pulses),
//   32-bit saturating counters.

module mem_aw_burst_issuer #(
  parameter int ADDR_WIDTH      = 64,
  parameter int REQ_SIZE_WIDTH  = 16,
  parameter int DATA_BYTES      = 64,
  parameter int MAX_BURST_BEATS = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [REQ_SIZE_WIDTH-1:0] req_size_bytes,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic                      pop_request,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [7:0]                m_awlen,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic                      busy,
  output logic                      overflow_err
`ifdef MEM_AW_BURST_ISSUER_STATS_EN
  ,
  output logic [31:0]               stat_bursts,
  output logic [31:0]               stat_requests
`endif
);

  localparam int OFS_W  = $clog2(DATA_BYTES);
  localparam int BEAT_W = REQ_SIZE_WIDTH + 1;
  // Width wide enough for both beat counts and the 4KB distance in beats.
  localparam int CALC_W = (BEAT_W > 13) ? BEAT_W : 13;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W:0]          DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0]   ALIGN_MASK = ~(ADDR_WIDTH'(DATA_BYTES - 1));
  localparam logic [BEAT_W-1:0]       ROUND_C    = BEAT_W'(DATA_BYTES - 1);
  localparam logic [CALC_W-1:0]       MAX_C      = CALC_W'(MAX_BURST_BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [BEAT_W-1:0]     fifo_beats_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic                  fifo_full_s, fifo_empty_s, wr_en_s, rd_en_s;
  logic [BEAT_W-1:0]     req_beats_s;
  logic                  overflow_q;

  assign fifo_full_s  = (count_q == DEPTH_C);
  assign fifo_empty_s = (count_q == '0);
  assign wr_en_s      = req_valid && !fifo_full_s;
  // Size is widened by one bit first so the rounding add cannot overflow.
  assign req_beats_s  = ({1'b0, req_size_bytes} + ROUND_C) >> OFS_W;

  // FSM state and datapath registers
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [BEAT_W-1:0]     rem_q, rem_d;
  logic [8:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic                  awvalid_q, awvalid_d;
  logic                  pop_q, pop_d;
  logic                  hs_s;

  assign rd_en_s = (state_q == IDLE) && !fifo_empty_s;
  assign hs_s    = awvalid_q && m_awready;

  // Occupancy count after this cycle's write and pop.
  always_comb begin
    count_d = count_q;
    if (wr_en_s && !rd_en_s) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (!wr_en_s && rd_en_s) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i]  <= '0;
        fifo_beats_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        fifo_addr_q[wr_ptr_q]  <= req_addr & ALIGN_MASK;
        fifo_beats_q[wr_ptr_q] <= req_beats_s;
        wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (req_valid && fifo_full_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------- burst sizing
  logic [12:0]       to4k_s;
  logic [CALC_W-1:0] min_s;
  logic [8:0]        len_s;
  logic [8:0]        len_m1_s;

  assign to4k_s = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> OFS_W;

  // len = min(rem_beats, MAX_BURST_BEATS, beats left before the 4KB line).
  always_comb begin
    min_s = CALC_W'(rem_q);
    if (MAX_C < min_s) begin
      min_s = MAX_C;
    end else begin
      min_s = min_s;
    end
    if (CALC_W'(to4k_s) < min_s) begin
      min_s = CALC_W'(to4k_s);
    end else begin
      min_s = min_s;
    end
  end

  assign len_s    = min_s[8:0];
  assign len_m1_s = len_s - 9'd1;

  // Next-state and output-register logic for the issue FSM.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    len_d      = len_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    awvalid_d  = awvalid_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          cur_addr_d = fifo_addr_q[rd_ptr_q];
          rem_d      = fifo_beats_q[rd_ptr_q];
          state_d    = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          len_d     = len_s;
          awaddr_d  = cur_addr_q;
          awlen_d   = len_m1_s[7:0];
          awvalid_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (m_awready) begin
          awvalid_d  = 1'b0;
          cur_addr_d = cur_addr_q + (ADDR_WIDTH'(len_q) << OFS_W);
          rem_d      = rem_q - BEAT_W'(len_q);
          if (rem_q == BEAT_W'(len_q)) begin
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
      end
    endcase
  end

  assign pop_d = (state_d == DONE);

  // FSM state, datapath and AW output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      len_q      <= 9'd0;
      awaddr_q   <= '0;
      awlen_q    <= 8'd0;
      awvalid_q  <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awvalid_q  <= awvalid_d;
      pop_q      <= pop_d;
    end
  end

  assign req_ready    = !fifo_full_s;
  assign pop_request  = pop_q;
  assign m_awaddr     = awaddr_q;
  assign m_awlen      = awlen_q;
  assign m_awvalid    = awvalid_q;
  assign busy         = !fifo_empty_s || (state_q != IDLE);
  assign overflow_err = overflow_q;

`ifdef MEM_AW_BURST_ISSUER_STATS_EN
  logic [31:0] stat_bursts_q, stat_requests_q;

  // Saturating burst and request counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bursts_q   <= 32'd0;
      stat_requests_q <= 32'd0;
    end else begin
      if (hs_s && (stat_bursts_q != 32'hFFFF_FFFF)) begin
        stat_bursts_q <= stat_bursts_q + 32'd1;
      end
      if (pop_q && (stat_requests_q != 32'hFFFF_FFFF)) begin
        stat_requests_q <= stat_requests_q + 32'd1;
      end
    end
  end

  assign stat_bursts   = stat_bursts_q;
  assign stat_requests = stat_requests_q;
`else
  logic unused_hs_s;
  assign unused_hs_s = hs_s;
`endif

endmodule

// File: tb/tb_mem_aw_burst_issuer.sv
module tb_mem_aw_burst_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] req_addr;
  logic [15:0] req_size_bytes;
  logic        req_valid;
  logic        req_ready;
  logic        pop_request;
  logic [63:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awvalid;
  logic        m_awready;
  logic        busy;
  logic        overflow_err;
`ifdef MEM_AW_BURST_ISSUER_STATS_EN
  logic [31:0] stat_bursts;
  logic [31:0] stat_requests;
`endif

  mem_aw_burst_issuer #(
    .ADDR_WIDTH(64), .REQ_SIZE_WIDTH(16), .DATA_BYTES(64),
    .MAX_BURST_BEATS(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_addr(req_addr), .req_size_bytes(req_size_bytes), .req_valid(req_valid),
    .req_ready(req_ready), .pop_request(pop_request),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .busy(busy), .overflow_err(overflow_err)
`ifdef MEM_AW_BURST_ISSUER_STATS_EN
    , .stat_bursts(stat_bursts), .stat_requests(stat_requests)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_pop;
    logic [63:0] addr;
    logic [7:0]  len;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  hs_cnt  = 0;
  int  pop_cnt = 0;
  int  last_hs = 0;
  int  last_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_aw(input logic [63:0] a, input logic [7:0] l);
    ev_t e;
    e.is_pop = 1'b0; e.addr = a; e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic push_pop();
    ev_t e;
    e.is_pop = 1'b1; e.addr = 64'd0; e.len = 8'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: every AW handshake and pop_request consumes the next expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_awvalid && m_awready) begin
        hs_cnt++;
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          chk("aw_unexpected", 64'd1, 64'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("aw_kind_is_pop", {63'd0, e.is_pop}, 64'd0);
          chk("aw_addr", m_awaddr, e.addr);
          chk("aw_len", {56'd0, m_awlen}, {56'd0, e.len});
        end
      end
      if (pop_request) begin
        pop_cnt++;
        last_pop = cyc;
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 64'd1, 64'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("pop_kind_is_pop", {63'd0, e.is_pop}, 64'd1);
        end
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [15:0] s, output int c0);
    req_addr = a; req_size_bytes = s; req_valid = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_awvalid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_awvalid && n < 50);
    if (!m_awvalid) chk({name, "_awvalid_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < limit);
    chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int c0, h0, p0, d;
    reset = 1'b1; req_valid = 1'b0; req_addr = 64'd0; req_size_bytes = 16'd0;
    m_awready = 1'b0;
    #12;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_pop_request", {63'd0, pop_request}, 64'd0);
    chk("rst_awvalid", {63'd0, m_awvalid}, 64'd0);
    chk("rst_awaddr", m_awaddr, 64'd0);
    chk("rst_awlen", {56'd0, m_awlen}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_overflow", {63'd0, overflow_err}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Single burst, latency to first awvalid and to pop.
    m_awready = 1'b1;
    push_aw(64'h1000, 8'd3); push_pop();
    send(64'h1000, 16'd256, c0);
    wait_awvalid("t1");
    chk("t1_latency", 64'(cyc - c0), 64'd3);
    drain("t1", 20);
    d = last_pop - last_hs;
    chk("t1_pop_after_hs_1to2", 64'((d >= 1 && d <= 2) ? 1 : 0), 64'd1);

    // 4KB request split by MAX_BURST_BEATS.
    push_aw(64'h0, 8'd15); push_aw(64'h400, 8'd15);
    push_aw(64'h800, 8'd15); push_aw(64'hC00, 8'd15); push_pop();
    send(64'h0, 16'd4096, c0);
    drain("t2", 60);

    // Request crossing a 4KB line.
    push_aw(64'hF80, 8'd1); push_aw(64'h1000, 8'd3); push_pop();
    send(64'hF80, 16'h0180, c0);
    drain("t3", 40);

    // Unaligned address and partial-beat size.
    push_aw(64'h5000, 8'd1); push_pop();
    send(64'h5023, 16'd100, c0);
    drain("t_align", 30);

    // Maximum size: 1024 beats from 0x10000.
    for (int i = 0; i < 64; i++) push_aw(64'h10000 + 64'(i) * 64'h400, 8'd15);
    push_pop();
    send(64'h10000, 16'hFFFF, c0);
    drain("t_max", 400);

    // Stall in ISSUE: outputs held, one handshake.
    m_awready = 1'b0;
    h0 = hs_cnt;
    push_aw(64'h2000, 8'd1); push_pop();
    send(64'h2000, 16'd128, c0);
    wait_awvalid("t4");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_awvalid", {63'd0, m_awvalid}, 64'd1);
      chk("t4_hold_awaddr", m_awaddr, 64'h2000);
      chk("t4_hold_awlen", {56'd0, m_awlen}, 64'd1);
    end
    m_awready = 1'b1;
    drain("t4", 20);
    chk("t4_one_handshake", 64'(hs_cnt - h0), 64'd1);

    // Overflow: FSM stalled on A, four queued, fifth dropped.
    m_awready = 1'b0;
    p0 = pop_cnt;
    push_aw(64'h6000, 8'd0); push_pop();
    send(64'h6000, 16'd64, c0);
    wait_awvalid("t5");
    for (int i = 0; i < 4; i++) begin
      push_aw(64'h7000 + 64'(i) * 64'h100, 8'd0); push_pop();
      if (i == 3) chk("t5_ready_before_4th", {63'd0, req_ready}, 64'd1);
      send(64'h7000 + 64'(i) * 64'h100, 16'd64, c0);
    end
    chk("t5_ready_low_full", {63'd0, req_ready}, 64'd0);
    chk("t5_no_overflow_yet", {63'd0, overflow_err}, 64'd0);
    send(64'h7F00, 16'd64, c0);
    chk("t5_overflow_set", {63'd0, overflow_err}, 64'd1);
    m_awready = 1'b1;
    drain("t5", 60);
    chk("t5_pop_count", 64'(pop_cnt - p0), 64'd5);
    chk("t5_overflow_sticky", {63'd0, overflow_err}, 64'd1);

    // Zero-size request: pop only.
    h0 = hs_cnt;
    push_pop();
    send(64'h3000, 16'd0, c0);
    drain("t6", 20);
    chk("t6_no_handshake", 64'(hs_cnt - h0), 64'd0);

    // Reset while ISSUE is stalled.
    m_awready = 1'b0;
    push_aw(64'h4000, 8'd0); push_pop();
    send(64'h4000, 16'd64, c0);
    wait_awvalid("t7");
    #2 reset = 1'b1;
    #1;
    chk("t7_awvalid_async", {63'd0, m_awvalid}, 64'd0);
    chk("t7_busy", {63'd0, busy}, 64'd0);
    chk("t7_overflow_cleared", {63'd0, overflow_err}, 64'd0);
    chk("t7_req_ready", {63'd0, req_ready}, 64'd1);
    exp_q.delete();
    p0 = pop_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    m_awready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("t7_no_pop_after_reset", 64'(pop_cnt - p0), 64'd0);
    chk("t7_idle_busy", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
